hazard_scheduler: RTL and testbench

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/hazard_scheduler_if.sv | 46 ++++
 rtl/hazard_scheduler.sv | 170 +++++++++++++++++
 tb/tb_hazard_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_scheduler_if.sv
// rtl/hazard_scheduler_if.sv - pipeline hazard bundle between the datapath and the hazard scheduler
interface hazard_scheduler_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic             LoadE;
  logic             PCSrcE;
  logic             RegWriteM;
  logic [4:0]       RdM;
  logic             RegWriteW;
  logic [4:0]       RdW;
  logic             MemAccessM;
  logic             mem_ready;
  logic             clr_cnt;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             mem_req;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, LoadE, PCSrcE,
    output RegWriteM, RdM, RegWriteW, RdW, MemAccessM, mem_ready, clr_cnt,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, mem_req, mem_err, stall_cycles
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, LoadE, PCSrcE,
    input  RegWriteM, RdM, RegWriteW, RdW, MemAccessM, mem_ready, clr_cnt,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, mem_req, mem_err, stall_cycles
  );
endinterface

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - forwarding, load-use, branch flush and data-memory wait/timeout control
module hazard_scheduler #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_scheduler_if.slave hz
);

  localparam int WW = $clog2(TIMEOUT + 1);
  // wait_cnt holds the stall cycles already spent; the abort is taken once the
  // current stall cycle is the TIMEOUT-th one, so a never-ready access stalls TIMEOUT cycles.
  localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ABORT} state_t;

  state_t           state;
  state_t           state_next;
  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_cnt_next;
  logic             mem_err_q;
  logic             mem_err_next;
  logic [CNT_W-1:0] stall_cnt;

  logic             lw_stall;
  logic             mem_miss;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic             req;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wm,
    input logic [4:0] rdm,
    input logic       ww,
    input logic [4:0] rdw
  );
    if (wm && (rdm != 5'd0) && (rdm == rs)) begin
      return 2'b10;
    end else if (ww && (rdw != 5'd0) && (rdw == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    lw_stall = hz.LoadE && (hz.RdE != 5'd0) &&
               ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    mem_miss = (state != ABORT) && hz.MemAccessM && !hz.mem_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      mem_err_q <= mem_err_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    mem_err_next  = 1'b0;
    case (state)
      RUN: begin
        if (mem_miss) begin
          if (TIMEOUT == 1) begin
            state_next    = ABORT;
            wait_cnt_next = '0;
            mem_err_next  = 1'b1;
          end else begin
            state_next    = MEM_WAIT;
            wait_cnt_next = WW'(1);
          end
        end
      end
      MEM_WAIT: begin
        if (!mem_miss) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == LAST_WAIT) begin
          state_next    = ABORT;
          wait_cnt_next = '0;
          mem_err_next  = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      ABORT: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Priority: reset bubble > memory wait > branch flush / load-use.
  always_comb begin
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    req     = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      fwd_a = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
      fwd_b = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
      req   = (state != ABORT) && hz.MemAccessM;
      if (mem_miss) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        stall_f = lw_stall;
        stall_d = lw_stall;
        flush_d = hz.PCSrcE;
        flush_e = hz.PCSrcE || lw_stall;
        flush_w = (state == ABORT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || hz.clr_cnt) begin
      stall_cnt <= '0;
    end else if (stall_f && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hz.ForwardAE    = fwd_a;
  assign hz.ForwardBE    = fwd_b;
  assign hz.StallF       = stall_f;
  assign hz.StallD       = stall_d;
  assign hz.StallE       = stall_e;
  assign hz.StallM       = stall_m;
  assign hz.FlushD       = flush_d;
  assign hz.FlushE       = flush_e;
  assign hz.FlushW       = flush_w;
  assign hz.mem_req      = req;
  // Suppressed under reset so a reset landing on the abort cycle reports nothing.
  assign hz.mem_err      = mem_err_q && !rst;
  assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - vector table and multi-cycle sequences for hazard_scheduler
module tb_hazard_scheduler;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scheduler_if #(.CNT_W(CNT_W)) hz ();

  hazard_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       clr;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       loade, pcsrce, regwm, regww, memacc, ready;
    logic [1:0] fa, fb;
    logic       sf, sd, se, sm, fd, fe, fw, mreq, merr;
  } vec_t;

  typedef struct {
    string       name;
    logic [16:0] exp;
  } sb_t;

  sb_t        sb[$];
  vec_t       tbl[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_sc = 4'd0;

  function automatic vec_t idle(input string name);
    vec_t v;
    v.name = name; v.rst = 1'b0; v.clr = 1'b0;
    v.rs1d = '0; v.rs2d = '0; v.rs1e = '0; v.rs2e = '0; v.rde = '0; v.rdm = '0; v.rdw = '0;
    v.loade = 1'b0; v.pcsrce = 1'b0; v.regwm = 1'b0; v.regww = 1'b0;
    v.memacc = 1'b0; v.ready = 1'b0;
    v.fa = 2'b00; v.fb = 2'b00;
    v.sf = 1'b0; v.sd = 1'b0; v.se = 1'b0; v.sm = 1'b0;
    v.fd = 1'b0; v.fe = 1'b0; v.fw = 1'b0; v.mreq = 1'b0; v.merr = 1'b0;
    return v;
  endfunction

  function automatic vec_t miss(input string name);
    vec_t v = idle(name);
    v.memacc = 1'b1;
    v.sf = 1'b1; v.sd = 1'b1; v.se = 1'b1; v.sm = 1'b1; v.fw = 1'b1; v.mreq = 1'b1;
    return v;
  endfunction

  function automatic vec_t rst_vec(input string name);
    vec_t v = idle(name);
    v.rst = 1'b1; v.memacc = 1'b1; v.loade = 1'b1; v.rde = 5'd7; v.rs2d = 5'd7;
    v.regwm = 1'b1; v.rdm = 5'd5; v.rs1e = 5'd5;
    v.fd = 1'b1; v.fe = 1'b1; v.fw = 1'b1;
    return v;
  endfunction

  function automatic vec_t fwd(input string name, input logic wm, input logic [4:0] rdm,
                               input logic ww, input logic [4:0] rdw, input logic [4:0] rs1e,
                               input logic [4:0] rs2e, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v = idle(name);
    v.regwm = wm; v.rdm = rdm; v.regww = ww; v.rdw = rdw; v.rs1e = rs1e; v.rs2e = rs2e;
    v.fa = fa; v.fb = fb;
    return v;
  endfunction

  function automatic vec_t lu(input string name, input logic ld, input logic [4:0] rde,
                              input logic [4:0] rs1d, input logic [4:0] rs2d, input logic br,
                              input logic stall, input logic fd, input logic fe);
    vec_t v = idle(name);
    v.loade = ld; v.rde = rde; v.rs1d = rs1d; v.rs2d = rs2d; v.pcsrce = br;
    v.sf = stall; v.sd = stall; v.fd = fd; v.fe = fe;
    return v;
  endfunction

  task automatic step(input vec_t v);
    sb_t         e;
    logic [16:0] got;
    rst = v.rst;
    hz.clr_cnt = v.clr;
    hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e; hz.RdE = v.rde;
    hz.LoadE = v.loade; hz.PCSrcE = v.pcsrce;
    hz.RegWriteM = v.regwm; hz.RdM = v.rdm; hz.RegWriteW = v.regww; hz.RdW = v.rdw;
    hz.MemAccessM = v.memacc; hz.mem_ready = v.ready;
    sb.push_back('{v.name, {v.fa, v.fb, v.sf, v.sd, v.se, v.sm, v.fd, v.fe, v.fw,
                            v.mreq, v.merr, exp_sc}});
    @(negedge clk);
    got = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
           hz.FlushD, hz.FlushE, hz.FlushW, hz.mem_req, hz.mem_err, hz.stall_cycles};
    e = sb.pop_front();
    checks++;
    if (got !== e.exp) begin
      failures++;
      $display("FAIL %s: got fa,fb,sF,sD,sE,sM,fD,fE,fW,req,err,cnt=%b expected=%b",
               e.name, got, e.exp);
    end
    @(posedge clk);
    #1;
    if (v.rst || v.clr) exp_sc = 4'd0;
    else if (v.sf && exp_sc != 4'hF) exp_sc = exp_sc + 4'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1;
    v = idle("preroll");
    hz.clr_cnt = 0; hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.LoadE = 0; hz.PCSrcE = 0; hz.RegWriteM = 0; hz.RdM = 0; hz.RegWriteW = 0; hz.RdW = 0;
    hz.MemAccessM = 0; hz.mem_ready = 0;
    repeat (2) @(posedge clk);
    #1;

    step(rst_vec("reset_outputs"));

    tbl.push_back(fwd("fwd_m_wins",   1, 5'd5, 1, 5'd5, 5'd5, 5'd0, 2'b10, 2'b00));
    tbl.push_back(fwd("fwd_rdm_zero", 1, 5'd0, 1, 5'd5, 5'd5, 5'd0, 2'b01, 2'b00));
    tbl.push_back(fwd("fwd_b_w_only", 1, 5'd3, 1, 5'd5, 5'd1, 5'd5, 2'b00, 2'b01));
    tbl.push_back(fwd("fwd_no_write", 0, 5'd5, 0, 5'd5, 5'd5, 5'd5, 2'b00, 2'b00));
    tbl.push_back(fwd("fwd_both_m",   1, 5'd9, 1, 5'd9, 5'd9, 5'd9, 2'b10, 2'b10));
    tbl.push_back(lu("lu_rs2",        1, 5'd7, 5'd0, 5'd7, 0, 1, 0, 1));
    tbl.push_back(lu("lu_rs1",        1, 5'd7, 5'd7, 5'd0, 0, 1, 0, 1));
    tbl.push_back(lu("lu_rd_zero",    1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0));
    tbl.push_back(lu("lu_not_load",   0, 5'd7, 5'd7, 5'd7, 0, 0, 0, 0));
    tbl.push_back(lu("branch",        0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1));
    tbl.push_back(lu("branch_and_lu", 1, 5'd4, 5'd4, 5'd0, 1, 1, 1, 1));
    v = idle("mem_hit"); v.memacc = 1; v.ready = 1; v.mreq = 1;
    tbl.push_back(v);
    v = idle("clr_cnt"); v.clr = 1;
    tbl.push_back(v);
    tbl.push_back(idle("after_clr"));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    for (int i = 0; i < 3; i++) step(miss($sformatf("wait3_c%0d", i)));
    v = idle("wait3_ready"); v.memacc = 1; v.ready = 1; v.mreq = 1;
    step(v);
    step(idle("wait3_count"));
    v = idle("wait3_clr"); v.clr = 1;
    step(v);

    for (int i = 0; i < TIMEOUT; i++) step(miss($sformatf("timeout_c%0d", i)));
    v = idle("abort_cycle"); v.memacc = 1; v.pcsrce = 1;
    v.fw = 1; v.fd = 1; v.fe = 1; v.merr = 1;
    step(v);
    step(idle("after_abort"));

    for (int i = 0; i < 2; i++) begin
      v = miss($sformatf("simul_c%0d", i));
      v.pcsrce = 1; v.loade = 1; v.rde = 5'd6; v.rs1d = 5'd6;
      step(v);
    end
    v = idle("simul_release"); v.memacc = 1; v.ready = 1; v.pcsrce = 1;
    v.loade = 1; v.rde = 5'd6; v.rs1d = 5'd6;
    v.mreq = 1; v.sf = 1; v.sd = 1; v.fd = 1; v.fe = 1;
    step(v);
    step(idle("simul_after"));

    for (int i = 0; i < 3; i++) step(miss($sformatf("rst_wait_c%0d", i)));
    step(rst_vec("rst_in_wait"));
    step(idle("rst_wait_no_err0"));
    step(idle("rst_wait_no_err1"));

    for (int i = 0; i < TIMEOUT; i++) step(miss($sformatf("rst_abort_c%0d", i)));
    step(rst_vec("rst_in_abort"));
    step(idle("rst_abort_no_err"));

    for (int i = 0; i < 20; i++) step(lu($sformatf("sat_c%0d", i), 1, 5'd7, 5'd0, 5'd7, 0, 1, 0, 1));
    step(idle("sat_hold"));
    v = idle("sat_clr"); v.clr = 1;
    step(v);
    step(idle("sat_cleared"));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
